// File: rtl/debug_baud_pkg.sv
// Shared types and constants for the debug UART baud sequencing controller.
package debug_baud_pkg;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2,
        BREAK  = 2'd3
    } baud_state_e;

    localparam int SUB_TICKS  = 32;
    localparam int ARM_CYCLES = 2;

endpackage

// File: rtl/debug_baud_ctrl_if.sv
// Detector/host-facing signal bundle of the baud controller.
interface debug_baud_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             rx;
    logic             ab_wr;
    logic [DIV_W-1:0] ab_div;
    logic             ab_rst_n;
    logic             cfg_wr;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_lock;
    logic             cfg_rearm;
    logic             baud_wr;
    logic [DIV_W-1:0] baud_div;
    logic             locked;
    logic             bit_tick;
    logic             brk_det;

    modport master (
        output rx, ab_wr, ab_div, cfg_wr, cfg_div, cfg_lock, cfg_rearm,
        input  ab_rst_n, baud_wr, baud_div, locked, bit_tick, brk_det
    );

    modport slave (
        input  rx, ab_wr, ab_div, cfg_wr, cfg_div, cfg_lock, cfg_rearm,
        output ab_rst_n, baud_wr, baud_div, locked, bit_tick, brk_det
    );
endinterface

// File: rtl/debug_baud_prescaler.sv
// Divides clk by div (pre_cnt) and then by SUB_TICKS (sub_cnt) to form bit_tick.
module debug_baud_prescaler
    import debug_baud_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             bit_tick
);
    localparam int SUB_W = $clog2(SUB_TICKS);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_TICKS - 1);

    logic [DIV_W-1:0] pre_cnt;
    logic [SUB_W-1:0] sub_cnt;
    logic             pre_wrap;

    assign pre_wrap = (pre_cnt == div - DIV_W'(1));
    assign bit_tick = en && pre_wrap && (sub_cnt == SUB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            sub_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
            sub_cnt <= '0;
        end else if (en) begin
            if (pre_wrap) begin
                pre_cnt <= '0;
                sub_cnt <= sub_cnt + SUB_W'(1);
            end else begin
                pre_cnt <= pre_cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/debug_baud_ctrl.sv
// Auto-baud lifecycle sequencer: arms the detector, captures its divisor,
// runs the baud prescaler and re-arms detection on an RX break.
module debug_baud_ctrl
    import debug_baud_pkg::*;
#(
    parameter int DIV_W      = 8,
    parameter int BREAK_BITS = 12
) (
    input logic             clk,
    input logic             rst,
    debug_baud_ctrl_if.slave bus
);
    localparam int BRK_W = $clog2(BREAK_BITS + 1);
    localparam logic [BRK_W-1:0] BRK_MAX = BRK_W'(BREAK_BITS);
    localparam logic [BRK_W-1:0] BRK_PRE = BRK_W'(BREAK_BITS - 1);

    baud_state_e      state_q, state_d;
    logic [1:0]       arm_cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             baud_wr_q;
    logic             brk_det_q;
    logic             brk_hold_q;
    logic [BRK_W-1:0] brk_cnt_q;
    logic             in_locked, cfg_acc, ab_acc, lock_entry;
    logic             bit_tick, brk_sat, brk_hit;

    assign in_locked  = (state_q == LOCKED);
    assign cfg_acc    = !bus.cfg_rearm && bus.cfg_wr && (bus.cfg_div != '0);
    assign ab_acc     = !bus.cfg_rearm && !cfg_acc && (state_q == HUNT)
                        && bus.ab_wr && (bus.ab_div != '0);
    assign lock_entry = cfg_acc || ab_acc;
    assign brk_sat    = in_locked && (brk_cnt_q == BRK_MAX);
    assign brk_hit    = in_locked && bit_tick && !bus.rx && !brk_hold_q
                        && (brk_cnt_q == BRK_PRE) && !lock_entry && !bus.cfg_rearm;

    debug_baud_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (lock_entry),
        .en       (in_locked),
        .div      (div_q),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (arm_cnt_q == 2'(ARM_CYCLES - 1)) state_d = HUNT;
            HUNT:    state_d = HUNT;
            LOCKED:  if (brk_sat && !bus.cfg_lock) state_d = BREAK;
            BREAK:   if (bus.rx) state_d = ARM;
            default: state_d = ARM;
        endcase
        if (lock_entry)    state_d = LOCKED;
        if (bus.cfg_rearm) state_d = ARM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARM;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            // a rearm while already arming restarts the hold-off
            arm_cnt_q <= (state_q == ARM && state_d == ARM && !bus.cfg_rearm)
                         ? arm_cnt_q + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            baud_wr_q <= 1'b0;
        end else begin
            baud_wr_q <= lock_entry;
            if (cfg_acc)     div_q <= bus.cfg_div;
            else if (ab_acc) div_q <= bus.ab_div;
        end
    end

    // brk_hold keeps a locked-through break from re-firing until rx returns high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            brk_cnt_q  <= '0;
            brk_hold_q <= 1'b0;
            brk_det_q  <= 1'b0;
        end else begin
            brk_det_q <= brk_hit;
            if (!in_locked || lock_entry || bus.rx) begin
                brk_cnt_q  <= '0;
                brk_hold_q <= 1'b0;
            end else if (brk_sat) begin
                brk_cnt_q  <= '0;
                brk_hold_q <= 1'b1;
            end else if (bit_tick && !brk_hold_q && brk_cnt_q != BRK_MAX) begin
                brk_cnt_q <= brk_cnt_q + BRK_W'(1);
            end
        end
    end

    assign bus.ab_rst_n = (state_q != ARM);
    assign bus.baud_wr  = baud_wr_q;
    assign bus.baud_div = div_q;
    assign bus.locked   = in_locked;
    assign bus.bit_tick = bit_tick;
    assign bus.brk_det  = brk_det_q;
endmodule

// File: tb/tb_debug_baud_ctrl.sv
// Directed bench for debug_baud_ctrl with hand-computed expectations.
module tb_debug_baud_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    debug_baud_ctrl_if #(.DIV_W(8)) bus ();

    debug_baud_ctrl #(.DIV_W(8), .BREAK_BITS(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int first_tick, last_tick, n_tick;
        int n_brk, brk_at, n_unlocked;

        bus.rx        = 1'b1;
        bus.ab_wr     = 1'b0;
        bus.ab_div    = '0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_lock  = 1'b0;
        bus.cfg_rearm = 1'b0;

        // reset values
        step();
        step();
        chk("rst_ab_rst_n", bus.ab_rst_n, 0);
        chk("rst_locked",   bus.locked,   0);
        chk("rst_baud_div", bus.baud_div, 0);
        chk("rst_baud_wr",  bus.baud_wr,  0);
        chk("rst_bit_tick", bus.bit_tick, 0);
        chk("rst_brk_det",  bus.brk_det,  0);

        // reset release: ab_rst_n low for 2 cycles
        rst = 1'b0;
        chk("arm_c0_ab_rst_n", bus.ab_rst_n, 0);
        step();
        chk("arm_c1_ab_rst_n", bus.ab_rst_n, 0);
        step();
        chk("arm_c2_ab_rst_n", bus.ab_rst_n, 1);
        chk("hunt_locked",     bus.locked,   0);
        chk("hunt_baud_div",   bus.baud_div, 0);

        // zero-divisor writes are ignored
        bus.ab_wr = 1'b1; bus.ab_div = 8'd0;
        step();
        bus.ab_wr = 1'b0;
        chk("ab_zero_baud_wr", bus.baud_wr, 0);
        chk("ab_zero_locked",  bus.locked,  0);
        bus.cfg_wr = 1'b1; bus.cfg_div = 8'd0;
        step();
        bus.cfg_wr = 1'b0;
        chk("cfg_zero_baud_wr",  bus.baud_wr,  0);
        chk("cfg_zero_locked",   bus.locked,   0);
        chk("cfg_zero_baud_div", bus.baud_div, 0);
        chk("cfg_zero_ab_rst_n", bus.ab_rst_n, 1);

        // auto-baud capture, div=3 -> ticks at 96, 192, 288
        bus.ab_wr = 1'b1; bus.ab_div = 8'd3;
        step();
        bus.ab_wr = 1'b0;
        chk("cap_baud_wr",  bus.baud_wr,  1);
        chk("cap_baud_div", bus.baud_div, 3);
        chk("cap_locked",   bus.locked,   1);
        first_tick = 0; last_tick = 0; n_tick = 0;
        for (int k = 1; k <= 290; k++) begin
            if (k == 2) chk("cap_baud_wr_pulse", bus.baud_wr, 0);
            if (bus.bit_tick === 1'b1) begin
                n_tick++;
                if (first_tick == 0) first_tick = k;
                last_tick = k;
            end
            step();
        end
        chk("tick_first", first_tick, 96);
        chk("tick_last",  last_tick,  288);
        chk("tick_count", n_tick,     3);

        // re-entry via cfg_wr while locked, then a 12-bit break
        bus.cfg_wr = 1'b1; bus.cfg_div = 8'd3;
        step();
        bus.cfg_wr = 1'b0;
        bus.rx = 1'b0;
        chk("reentry_baud_wr", bus.baud_wr, 1);
        chk("reentry_locked",  bus.locked,  1);
        n_brk = 0; brk_at = 0;
        for (int k = 1; k <= 1200; k++) begin
            if (bus.brk_det === 1'b1) begin
                n_brk++;
                brk_at = k;
            end
            step();
        end
        chk("brk_count",    n_brk,        1);
        chk("brk_cycle",    brk_at,       1153);
        chk("brk_locked",   bus.locked,   0);
        chk("brk_ab_rst_n", bus.ab_rst_n, 1);
        bus.rx = 1'b1;
        step();
        chk("rearm_c0_ab_rst_n", bus.ab_rst_n, 0);
        step();
        chk("rearm_c1_ab_rst_n", bus.ab_rst_n, 0);
        step();
        chk("rearm_c2_ab_rst_n", bus.ab_rst_n, 1);
        chk("rearm_baud_div",    bus.baud_div, 3);
        chk("rearm_locked",      bus.locked,   0);

        // break while cfg_lock=1: one pulse, stays locked
        bus.cfg_lock = 1'b1;
        bus.cfg_wr = 1'b1; bus.cfg_div = 8'd3;
        step();
        bus.cfg_wr = 1'b0;
        bus.rx = 1'b0;
        n_brk = 0; brk_at = 0; n_unlocked = 0;
        for (int k = 1; k <= 2500; k++) begin
            if (bus.brk_det === 1'b1) begin
                n_brk++;
                brk_at = k;
            end
            if (bus.locked !== 1'b1) n_unlocked++;
            step();
        end
        chk("lock_brk_count", n_brk,      1);
        chk("lock_brk_cycle", brk_at,     1153);
        chk("lock_unlocked",  n_unlocked, 0);
        bus.rx = 1'b1;
        bus.cfg_lock = 1'b0;
        step();

        // rearm from LOCKED
        bus.cfg_rearm = 1'b1;
        step();
        bus.cfg_rearm = 1'b0;
        chk("rearm_locked_drop", bus.locked,   0);
        chk("rearm_bit_tick",    bus.bit_tick, 0);
        chk("rearm_ab_rst_n",    bus.ab_rst_n, 0);
        step();
        step();
        chk("rearm_hunt_ab_rst_n", bus.ab_rst_n, 1);

        // cfg_wr beats ab_wr
        bus.cfg_wr = 1'b1; bus.cfg_div = 8'd5;
        bus.ab_wr  = 1'b1; bus.ab_div  = 8'd7;
        step();
        bus.cfg_wr = 1'b0; bus.ab_wr = 1'b0;
        chk("prio_baud_div", bus.baud_div, 5);
        chk("prio_baud_wr",  bus.baud_wr,  1);
        chk("prio_locked",   bus.locked,   1);

        // cfg_rearm beats cfg_wr
        bus.cfg_rearm = 1'b1;
        bus.cfg_wr = 1'b1; bus.cfg_div = 8'd9;
        step();
        bus.cfg_rearm = 1'b0; bus.cfg_wr = 1'b0;
        chk("prio2_locked",   bus.locked,   0);
        chk("prio2_ab_rst_n", bus.ab_rst_n, 0);
        chk("prio2_baud_div", bus.baud_div, 5);
        chk("prio2_baud_wr",  bus.baud_wr,  0);

        // async reset mid-LOCKED
        step();
        step();
        bus.cfg_wr = 1'b1; bus.cfg_div = 8'd5;
        step();
        bus.cfg_wr = 1'b0;
        chk("pre_rst_locked", bus.locked, 1);
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("arst_ab_rst_n", bus.ab_rst_n, 0);
        chk("arst_locked",   bus.locked,   0);
        chk("arst_baud_div", bus.baud_div, 0);
        chk("arst_baud_wr",  bus.baud_wr,  0);
        chk("arst_bit_tick", bus.bit_tick, 0);
        chk("arst_brk_det",  bus.brk_det,  0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
